multiplier_unsigned_multicycle: RTL and testbench



---
 rtl/mul_pkg.sv | 24 ++
 rtl/mulu_step.sv | 31 +++
 rtl/multiplier_unsigned_multicycle.sv | 144 ++++++++++++++
 tb/tb_multiplier_unsigned_multicycle.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// mul_pkg: shared state encoding, default width and iteration-count helpers
// for the iterative shift-add unsigned multiplier.
package mul_pkg;

   localparam int unsigned MUL_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mul_state_t;

   // Iterations needed to consume a width-bit multiplier at bpc bits per step.
   function automatic int unsigned mul_num_iters(input int unsigned width,
                                                 input int unsigned bpc);
      return (bpc == 0) ? width : width / bpc;
   endfunction

   // Counter width able to represent 0..iters inclusive.
   function automatic int unsigned mul_cnt_width(input int unsigned iters);
      return (iters < 2) ? 1 : $clog2(iters + 1);
   endfunction

endpackage

// File: rtl/mulu_step.sv
// mulu_step: one purely combinational shift-add iteration. Consumes
// BITS_PER_CYCLE multiplier bits, adding the correspondingly shifted
// multiplicand into the accumulator, then shifts both operand registers.
module mulu_step
   import mul_pkg::*;
#(
   parameter int unsigned WIDTH          = MUL_WIDTH,
   parameter int unsigned BITS_PER_CYCLE = 1
) (
   input  logic [2*WIDTH-1:0] i_acc,
   input  logic [2*WIDTH-1:0] i_mcand,
   input  logic [WIDTH-1:0]   i_mplier,
   output logic [2*WIDTH-1:0] o_acc,
   output logic [2*WIDTH-1:0] o_mcand,
   output logic [WIDTH-1:0]   o_mplier
);

   // Partial-sum chain: element j holds the accumulator after bits 0..j-1.
   logic [2*WIDTH-1:0] w_acc_chain [BITS_PER_CYCLE+1];

   assign w_acc_chain[0] = i_acc;

   for (genvar j = 0; j < BITS_PER_CYCLE; j++) begin : g_bit
      assign w_acc_chain[j+1] = w_acc_chain[j] + (i_mplier[j] ? (i_mcand << j) : '0);
   end

   assign o_acc    = w_acc_chain[BITS_PER_CYCLE];
   assign o_mcand  = i_mcand << BITS_PER_CYCLE;
   assign o_mplier = i_mplier >> BITS_PER_CYCLE;

endmodule

// File: rtl/multiplier_unsigned_multicycle.sv
// multiplier_unsigned_multicycle: iterative shift-add unsigned multiplier
// with valid/ready handshakes on operands and product. Produces a
// 2*WIDTH-bit product after WIDTH/BITS_PER_CYCLE BUSY iterations.
// Optional macro MUL_EARLY_TERM_EN: leave BUSY as soon as the remaining
// multiplier bits are all zero (same product, shorter latency).
module multiplier_unsigned_multicycle
   import mul_pkg::*;
#(
   parameter int unsigned WIDTH          = MUL_WIDTH,
   parameter int unsigned BITS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_multiplicand,
   input  logic [WIDTH-1:0] i_multiplier,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_product_hi,
   output logic [WIDTH-1:0] o_product_lo
);

   localparam int unsigned     N        = mul_num_iters(WIDTH, BITS_PER_CYCLE);
   localparam int unsigned     CNT_W    = mul_cnt_width(N);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

   mul_state_t         r_state;
   mul_state_t         w_state_nxt;
   logic [2*WIDTH-1:0] r_acc;
   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [CNT_W-1:0]   r_count;
   logic [WIDTH-1:0]   r_prod_hi;
   logic [WIDTH-1:0]   r_prod_lo;
   logic [2*WIDTH-1:0] w_acc_nxt;
   logic [2*WIDTH-1:0] w_mcand_nxt;
   logic [WIDTH-1:0]   w_mplier_nxt;
   logic               w_accept;
   logic               w_finish;

   mulu_step #(
      .WIDTH          (WIDTH),
      .BITS_PER_CYCLE (BITS_PER_CYCLE)
   ) u_step (
      .i_acc    (r_acc),
      .i_mcand  (r_mcand),
      .i_mplier (r_mplier),
      .o_acc    (w_acc_nxt),
      .o_mcand  (w_mcand_nxt),
      .o_mplier (w_mplier_nxt)
   );

   // Decide whether the iteration applied at this edge is the last one.
   always_comb begin
      w_finish = (r_count == LAST_CNT);
`ifdef MUL_EARLY_TERM_EN
      if (w_mplier_nxt == '0) begin
         w_finish = 1'b1;
      end
`endif
   end

   // Next-state and handshake outputs.
   always_comb begin
      w_state_nxt = r_state;
      o_ready     = 1'b0;
      o_valid     = 1'b0;
      w_accept    = 1'b0;
      case (r_state)
         IDLE: begin
            o_ready  = !rst;
            w_accept = i_valid && !rst;
            if (w_accept) begin
               w_state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (w_finish) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            o_valid = 1'b1;
            if (i_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // State register; reset from any state discards the in-flight operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Operand latch on accept, one shift-add iteration per BUSY cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_count  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_acc    <= '0;
                  r_mcand  <= {{WIDTH{1'b0}}, i_multiplicand};
                  r_mplier <= i_multiplier;
                  r_count  <= '0;
               end
            end
            BUSY: begin
               r_acc    <= w_acc_nxt;
               r_mcand  <= w_mcand_nxt;
               r_mplier <= w_mplier_nxt;
               r_count  <= r_count + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   // Product register captured from the final accumulator; held otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_prod_hi <= '0;
         r_prod_lo <= '0;
      end else if (r_state == BUSY && w_finish) begin
         r_prod_hi <= w_acc_nxt[2*WIDTH-1:WIDTH];
         r_prod_lo <= w_acc_nxt[WIDTH-1:0];
      end
   end

   assign o_product_hi = r_prod_hi;
   assign o_product_lo = r_prod_lo;

endmodule

// File: tb/tb_multiplier_unsigned_multicycle.sv
// tb_multiplier_unsigned_multicycle: scoreboard bench for the iterative
// unsigned multiplier. Directed cases run on a BITS_PER_CYCLE=1 instance;
// extra instances at 2/4/8 bits per cycle take random operands.
module tb_multiplier_unsigned_multicycle;

   typedef struct {
      logic [63:0] prod;
      int          lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   bit   sweep_go;
   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   always #5 clk = ~clk;

   // Main instance signals
   logic        m_ivalid;
   logic        m_oready;
   logic        m_ovalid;
   logic        m_iready;
   logic [31:0] m_a;
   logic [31:0] m_b;
   logic [31:0] m_hi;
   logic [31:0] m_lo;
   exp_t        sb[$];

   multiplier_unsigned_multicycle #(
      .WIDTH          (32),
      .BITS_PER_CYCLE (1)
   ) u_dut (
      .clk            (clk),
      .rst            (rst),
      .i_valid        (m_ivalid),
      .o_ready        (m_oready),
      .i_multiplicand (m_a),
      .i_multiplier   (m_b),
      .o_valid        (m_ovalid),
      .i_ready        (m_iready),
      .o_product_hi   (m_hi),
      .o_product_lo   (m_lo)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Expected cycles from accept edge to o_valid.
   function automatic int exp_lat(input logic [31:0] b, input int bpc);
      int it;
`ifdef MUL_EARLY_TERM_EN
      int bits;
      bits = 0;
      for (int i = 0; i < 32; i++) begin
         if (b[i]) bits = i + 1;
      end
      it = (bits + bpc - 1) / bpc;
      if (it < 1) it = 1;
`else
      it = 32 / bpc;
      if (b === 32'hx) it = 0;
`endif
      return it;
   endfunction

   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input int bp, input bit poke);
      exp_t e;
      int   lat;
      int   guard;
      guard = 0;
      while (!m_oready && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      check({tag, "_idle_ready"}, 64'(m_oready), 64'd1);
      m_iready = (bp == 0);
      m_a      = a;
      m_b      = b;
      m_ivalid = 1'b1;
      e.prod   = 64'(a) * 64'(b);
      e.lat    = exp_lat(b, 1);
      sb.push_back(e);
      @(posedge clk); #1;
      m_ivalid = 1'b0;
      check({tag, "_busy_ready"}, 64'(m_oready), 64'd0);
      lat = 0;
      while (!m_ovalid && lat < 200) begin
         if (poke && lat == 1) begin
            m_a = 32'h3; m_b = 32'h3; m_ivalid = 1'b1;
         end
         if (poke && lat == 4) m_ivalid = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      m_ivalid = 1'b0;
      check({tag, "_sb_nonempty"}, 64'(sb.size()), 64'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check({tag, "_lat"}, 64'(lat), 64'(e.lat));
         check({tag, "_prod"}, {m_hi, m_lo}, e.prod);
         if (bp > 0) begin
            repeat (bp) begin
               @(posedge clk); #1;
               check({tag, "_bp_valid"}, 64'(m_ovalid), 64'd1);
            end
            check({tag, "_bp_prod"}, {m_hi, m_lo}, e.prod);
            m_iready = 1'b1;
         end
         @(posedge clk); #1;
         check({tag, "_drop_valid"}, 64'(m_ovalid), 64'd0);
         check({tag, "_ready_back"}, 64'(m_oready), 64'd1);
         check({tag, "_idle_hold"}, {m_hi, m_lo}, e.prod);
      end
   endtask

   // Random-operand instances at wider step sizes
   for (genvar g = 0; g < 3; g++) begin : g_sweep
      localparam int unsigned BPC = 2 << g;
      logic        s_ivalid;
      logic        s_oready;
      logic        s_ovalid;
      logic [31:0] s_a;
      logic [31:0] s_b;
      logic [31:0] s_hi;
      logic [31:0] s_lo;
      bit          s_done;
      exp_t        s_sb[$];

      multiplier_unsigned_multicycle #(
         .WIDTH          (32),
         .BITS_PER_CYCLE (BPC)
      ) u_dut (
         .clk            (clk),
         .rst            (rst),
         .i_valid        (s_ivalid),
         .o_ready        (s_oready),
         .i_multiplicand (s_a),
         .i_multiplier   (s_b),
         .o_valid        (s_ovalid),
         .i_ready        (1'b1),
         .o_product_hi   (s_hi),
         .o_product_lo   (s_lo)
      );

      initial begin : p_sweep
         exp_t e;
         int   lat;
         s_ivalid = 1'b0;
         s_a      = '0;
         s_b      = '0;
         s_done   = 1'b0;
         wait (sweep_go);
         for (int i = 0; i < 8; i++) begin
            s_a = (i == 0) ? 32'hFFFF_FFFF : $urandom;
            s_b = (i == 0) ? 32'hFFFF_FFFF : (i == 1) ? 32'h0 : $urandom;
            check($sformatf("bpc%0d_ready", BPC), 64'(s_oready), 64'd1);
            s_ivalid = 1'b1;
            e.prod   = 64'(s_a) * 64'(s_b);
            e.lat    = exp_lat(s_b, int'(BPC));
            s_sb.push_back(e);
            @(posedge clk); #1;
            s_ivalid = 1'b0;
            lat = 0;
            while (!s_ovalid && lat < 100) begin
               @(posedge clk); #1;
               lat++;
            end
            e = s_sb.pop_front();
            check($sformatf("bpc%0d_lat", BPC), 64'(lat), 64'(e.lat));
            check($sformatf("bpc%0d_prod", BPC), {s_hi, s_lo}, e.prod);
            @(posedge clk); #1;
         end
         s_done = 1'b1;
      end
   end

   initial begin : p_main
      int t;
      int cnt;
      rst      = 1'b1;
      m_ivalid = 1'b0;
      m_a      = '0;
      m_b      = '0;
      m_iready = 1'b1;
      sweep_go = 1'b0;

      @(posedge clk); #1;
      check("rst_ready_low", 64'(m_oready), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("rst_valid", 64'(m_ovalid), 64'd0);
      check("rst_prod", {m_hi, m_lo}, 64'd0);
      check("rst_ready", 64'(m_oready), 64'd1);

      run_op("basic_7x6",   32'd7,          32'd6,          0, 1'b0);
      run_op("max",         32'hFFFF_FFFF,  32'hFFFF_FFFF,  0, 1'b0);
      run_op("cross_word",  32'h0001_0000,  32'h0001_0000,  0, 1'b0);
      run_op("zero_mcand",  32'h0,          32'hDEAD_BEEF,  0, 1'b0);
      run_op("zero_mplier", 32'hDEAD_BEEF,  32'h0,          0, 1'b0);
      run_op("one_mplier",  32'h1357_9BDF,  32'h1,          0, 1'b0);
      run_op("msb_mplier",  32'h0000_0003,  32'h8000_0000,  0, 1'b0);
      run_op("backpress",   32'h1234_5678,  32'h9ABC_DEF0,  5, 1'b0);
      run_op("busy_poke",   32'h0000_CAFE,  32'hFFFF_0001,  0, 1'b1);

      // Reset in the middle of an operation
      m_a = 32'h1234; m_b = 32'h5678; m_ivalid = 1'b1;
      @(posedge clk); #1;
      m_ivalid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("midrst_valid", 64'(m_ovalid), 64'd0);
      check("midrst_ready", 64'(m_oready), 64'd1);
      check("midrst_prod", {m_hi, m_lo}, 64'd0);
      cnt = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (m_ovalid) cnt++;
      end
      check("midrst_no_valid", 64'(cnt), 64'd0);
      run_op("after_rst_2x3", 32'd2, 32'd3, 0, 1'b0);

      sweep_go = 1'b1;
      t = 0;
      while (!(g_sweep[0].s_done && g_sweep[1].s_done && g_sweep[2].s_done) && t < 3000) begin
         @(posedge clk); #1;
         t++;
      end
      check("sweep_done",
            64'({g_sweep[2].s_done, g_sweep[1].s_done, g_sweep[0].s_done}), 64'h7);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
